nw_fill_controller: RTL and testbench

- Matrix-fill sequencer and cell evaluator for the Needleman-Wunsch score matrix.
- Sits directly downstream of the score manager: consumes the diag/up/left neighbour scores and the `signal` ready strobe.
- Computes each cell score and traceback direction, then drives the manager's write-side controls (max, en_ins, we) and index controls (i, j, en_read, change_index).
- Walks cells row-major from (1,1) to (N,N).

---
 rtl/nw_fill_controller.sv | 160 ++++++++++++++++
 tb/tb_nw_fill_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_fill_controller.sv
// Needleman-Wunsch matrix-fill sequencer: walks cells row-major, evaluates each
// cell from its three neighbours and drives the score manager's control strobes.
module nw_fill_controller #(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N+1),
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signal,
  input  logic signed [8:0]   diag,
  input  logic signed [8:0]   up,
  input  logic signed [8:0]   left,
  input  logic [1:0]          char_a,
  input  logic [1:0]          char_b,
  output logic [BitAddr:0]    i,
  output logic [BitAddr:0]    j,
  output logic                en_read,
  output logic                change_index,
  output logic                en_ins,
  output logic                we,
  output logic signed [8:0]   max,
  output logic [1:0]          dir,
  output logic                dir_we,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    ADV   = 3'd4,
    SYNC  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [BitAddr:0]   LAST     = (BitAddr+1)'(N);
  localparam logic [BitAddr:0]   ONE      = (BitAddr+1)'(1);
  localparam logic signed [10:0] S_MATCH  = 11'(MATCH);
  localparam logic signed [10:0] S_MISS   = 11'(MISMATCH);
  localparam logic signed [10:0] S_GAP    = 11'(GAP);
  localparam logic signed [10:0] SAT_HI   = 11'sd255;
  localparam logic signed [10:0] SAT_LO   = -11'sd256;
  localparam logic [1:0]         DIR_DIAG = 2'b00;
  localparam logic [1:0]         DIR_UP   = 2'b01;
  localparam logic [1:0]         DIR_LEFT = 2'b10;

  state_t state, state_next;

  logic signed [8:0]  diag_q, up_q, left_q;
  logic signed [10:0] cand_d, cand_u, cand_l, best;
  logic [1:0]         best_dir;
  logic signed [8:0]  best_sat;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (signal) state_next = CALC;
      CALC:    state_next = WRITE;
      WRITE:   state_next = (i == LAST && j == LAST) ? DONE : ADV;
      ADV:     state_next = SYNC;
      SYNC:    state_next = READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ties fall through in diag > up > left order because of the >= chain.
  always_comb begin
    cand_d   = 11'(diag_q) + ((char_a == char_b) ? S_MATCH : S_MISS);
    cand_u   = 11'(up_q) + S_GAP;
    cand_l   = 11'(left_q) + S_GAP;
    best     = cand_d;
    best_dir = DIR_DIAG;
    if (cand_d >= cand_u && cand_d >= cand_l) begin
      best     = cand_d;
      best_dir = DIR_DIAG;
    end else if (cand_u >= cand_l) begin
      best     = cand_u;
      best_dir = DIR_UP;
    end else begin
      best     = cand_l;
      best_dir = DIR_LEFT;
    end
    if (best > SAT_HI) begin
      best_sat = 9'sd255;
    end else if (best < SAT_LO) begin
      best_sat = -9'sd256;
    end else begin
      best_sat = best[8:0];
    end
  end

  // Strobes are registered from the next state so they align with the state they name.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      max          <= '0;
      dir          <= DIR_DIAG;
      diag_q       <= '0;
      up_q         <= '0;
      left_q       <= '0;
      en_read      <= 1'b0;
      change_index <= 1'b0;
      en_ins       <= 1'b0;
      we           <= 1'b0;
      dir_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      en_read      <= (state_next == READ);
      change_index <= (state_next == SYNC);
      en_ins       <= (state_next == WRITE);
      we           <= (state_next == WRITE);
      dir_we       <= (state_next == WRITE);
      done         <= (state_next == DONE);
      busy         <= (state_next == READ) || (state_next == CALC) ||
                      (state_next == WRITE) || (state_next == ADV) ||
                      (state_next == SYNC);
      case (state)
        IDLE: begin
          if (start) begin
            i <= ONE;
            j <= ONE;
          end
        end
        READ: begin
          if (signal) begin
            diag_q <= diag;
            up_q   <= up;
            left_q <= left;
          end
        end
        CALC: begin
          max <= best_sat;
          dir <= best_dir;
        end
        ADV: begin
          if (j == LAST) begin
            j <= ONE;
            i <= i + ONE;
          end else begin
            j <= j + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_fill_controller.sv
// Self-checking bench for nw_fill_controller (N=2): a scoreboard of expected
// cell writes is filled as neighbours are driven and drained on each we pulse.
module tb_nw_fill_controller;

  localparam int N  = 2;
  localparam int BA = $clog2(N+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              signal;
  logic signed [8:0] diag, up, left;
  logic [1:0]        char_a, char_b;
  logic [BA:0]       i, j;
  logic              en_read, change_index, en_ins, we, dir_we, busy, done;
  logic signed [8:0] max;
  logic [1:0]        dir;

  typedef struct {
    int ei;
    int ej;
    int emax;
    int edir;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   write_count = 0;
  int   ci_count = 0;
  int   done_count = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   done_cyc = 0;

  nw_fill_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .signal(signal),
    .diag(diag), .up(up), .left(left), .char_a(char_a), .char_b(char_b),
    .i(i), .j(j), .en_read(en_read), .change_index(change_index),
    .en_ins(en_ins), .we(we), .max(max), .dir(dir), .dir_we(dir_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard drain plus pulse counting, sampled on the falling edge.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      exp_t e;
      write_count++;
      last_we_cyc = cyc;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_write: got write at i=%0d j=%0d, required no write", i, j);
      end else begin
        e = sb.pop_front();
        if (i !== e.ei || j !== e.ej || max !== e.emax || dir !== e.edir) begin
          mismatched++;
          $display("[TB] FAIL cell_write: got i=%0d j=%0d max=%0d dir=%0d, required i=%0d j=%0d max=%0d dir=%0d",
                   i, j, max, dir, e.ei, e.ej, e.emax, e.edir);
        end
      end
      compared++;
      if (en_ins !== 1'b1 || dir_we !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL write_strobes: got en_ins=%b dir_we=%b, required 1 1", en_ins, dir_we);
      end
    end
    if (change_index === 1'b1) ci_count++;
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) begin
      compared++;
      if (i == 0 || i > N || j == 0 || j > N) begin
        mismatched++;
        $display("[TB] FAIL index_range: got i=%0d j=%0d while busy, required 1..%0d", i, j, N);
      end
    end
  end

  task automatic ref_cell(input int d, input int u, input int l, input logic [1:0] a,
                          input logic [1:0] b, output int emax, output int edir);
    int s, cd, cu, cl;
    s  = (a == b) ? 1 : -1;
    cd = d + s;
    cu = u - 2;
    cl = l - 2;
    if (cd >= cu && cd >= cl) begin
      emax = cd; edir = 0;
    end else if (cu >= cl) begin
      emax = cu; edir = 1;
    end else begin
      emax = cl; edir = 2;
    end
    if (emax > 255) emax = 255;
    if (emax < -256) emax = -256;
  endtask

  task automatic clear_counts();
    write_count = 0;
    ci_count    = 0;
    done_count  = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for READ, queues the expected write, then presents neighbours after a stall.
  task automatic applyStimulus(input int d, input int u, input int l, input logic [1:0] ca,
                               input logic [1:0] cb, input int stall, input int ei,
                               input int ej, input int emax, input int edir);
    int t = 0;
    while (en_read !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL read_wait: got no en_read within 200 cycles, required en_read=1");
      return;
    end
    sb.push_back('{ei: ei, ej: ej, emax: emax, edir: edir});
    diag   = 9'(d);
    up     = 9'(u);
    left   = 9'(l);
    char_a = ca;
    char_b = cb;
    repeat (stall) @(negedge clk);
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
  endtask

  task automatic applyModelCell(input int ei, input int ej, input int stall);
    int d, u, l, em, ed;
    logic [1:0] ca, cb;
    d  = int'($urandom_range(0, 511)) - 256;
    u  = int'($urandom_range(0, 511)) - 256;
    l  = int'($urandom_range(0, 511)) - 256;
    ca = 2'($urandom_range(0, 3));
    cb = ($urandom_range(0, 1) == 1) ? ca : 2'($urandom_range(0, 3));
    ref_cell(d, u, l, ca, cb, em, ed);
    applyStimulus(d, u, l, ca, cb, stall, ei, ej, em, ed);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    compared++;
    if (t >= 200) begin
      mismatched++;
      $display("[TB] FAIL %s_done_wait: got no done within 200 cycles, required done=1", name);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_after_done: got busy=%b done=%b, required 0 0", name, busy, done);
    end
  endtask

  task automatic check_reset_values(input string name);
    compared++;
    if (i !== 0 || j !== 0 || max !== 0 || dir !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL %s_regs: got i=%0d j=%0d max=%0d dir=%b, required 0 0 0 00",
               name, i, j, max, dir);
    end
    compared++;
    if ({en_read, change_index, en_ins, we, dir_we, busy, done} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_strobes: got %b, required 0000000", name,
               {en_read, change_index, en_ins, we, dir_we, busy, done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");
  endtask

  task automatic test_match_fill();
    clear_counts();
    do_start();
    compared++;
    if (busy !== 1'b1 || i !== 1 || j !== 1 || en_read !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL fill_start: got busy=%b i=%0d j=%0d en_read=%b, required 1 1 1 1",
               busy, i, j, en_read);
    end
    applyStimulus(5,   3,   2, 2'd1, 2'd1, 3, 1, 1, 6,  0);
    applyStimulus(0,   3,   0, 2'd0, 2'd2, 3, 1, 2, 1,  1);
    applyStimulus(0,   1,   1, 2'd0, 2'd3, 3, 2, 1, -1, 0);
    applyStimulus(-10, -10, 4, 2'd2, 2'd2, 3, 2, 2, 2,  2);
    wait_done("fill");
    compared++;
    if (write_count != 4 || ci_count != 3 || done_count != 1) begin
      mismatched++;
      $display("[TB] FAIL fill_counts: got writes=%0d change_index=%0d done=%0d, required 4 3 1",
               write_count, ci_count, done_count);
    end
    compared++;
    if (done_cyc - last_we_cyc != 1) begin
      mismatched++;
      $display("[TB] FAIL done_latency: got %0d cycles after last write, required 1",
               done_cyc - last_we_cyc);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (i !== N || j !== N || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: got i=%0d j=%0d pending=%0d, required %0d %0d 0",
               i, j, sb.size(), N, N);
    end
  endtask

  task automatic test_saturation_start_abuse();
    clear_counts();
    do_start();
    applyStimulus(-256, -256, -256, 2'd0, 2'd1, 0, 1, 1, -256, 0);
    do_start();
    applyStimulus(255, 0, 0, 2'd3, 2'd3, 1, 1, 2, 255, 0);
    do_start();
    applyModelCell(2, 1, 0);
    applyModelCell(2, 2, 2);
    wait_done("abuse");
    compared++;
    if (write_count != 4 || done_count != 1 || ci_count != 3) begin
      mismatched++;
      $display("[TB] FAIL abuse_counts: got writes=%0d done=%0d change_index=%0d, required 4 1 3",
               write_count, done_count, ci_count);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    clear_counts();
    do_start();
    for (int k = 0; k < 50; k++) begin
      compared++;
      if (en_read !== 1'b1 || we !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        bad++;
        if (bad < 4)
          $display("[TB] FAIL stall_read: got en_read=%b we=%b busy=%b at cycle %0d, required 1 0 1",
                   en_read, we, busy, k);
      end
      @(negedge clk);
    end
    for (int r = 1; r <= N; r++)
      for (int c = 1; c <= N; c++)
        applyModelCell(r, c, 0);
    wait_done("stall");
    compared++;
    if (write_count != 4) begin
      mismatched++;
      $display("[TB] FAIL stall_writes: got %0d, required 4", write_count);
    end
  endtask

  task automatic test_reset_midfill();
    int wc;
    clear_counts();
    do_start();
    applyModelCell(1, 1, 0);
    applyModelCell(1, 2, 0);
    @(negedge clk);
    compared++;
    if (we !== 1'b1 || i !== 1 || j !== 2) begin
      mismatched++;
      $display("[TB] FAIL midfill_write: got we=%b i=%0d j=%0d, required 1 1 2", we, i, j);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midfill_reset");
    rst = 1'b0;
    wc = write_count;
    repeat (10) @(negedge clk);
    compared++;
    if (write_count != wc || busy !== 1'b0 || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL post_reset: got writes=%0d busy=%b pending=%0d, required %0d 0 0",
               write_count, busy, sb.size(), wc);
    end
  endtask

  task automatic test_back_to_back();
    for (int run = 0; run < 2; run++) begin
      clear_counts();
      do_start();
      compared++;
      if (i !== 1 || j !== 1 || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL restart_index: got i=%0d j=%0d busy=%b, required 1 1 1", i, j, busy);
      end
      for (int r = 1; r <= N; r++)
        for (int c = 1; c <= N; c++)
          applyModelCell(r, c, int'($urandom_range(0, 2)));
      wait_done("b2b");
      compared++;
      if (write_count != 4 || ci_count != 3 || done_count != 1) begin
        mismatched++;
        $display("[TB] FAIL b2b_counts: got writes=%0d change_index=%0d done=%0d, required 4 3 1",
                 write_count, ci_count, done_count);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    signal = 1'b0;
    diag   = '0;
    up     = '0;
    left   = '0;
    char_a = '0;
    char_b = '0;
    test_reset();
    test_match_fill();
    test_saturation_start_abuse();
    test_stall();
    test_reset_midfill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
